p2s_lanes_param: RTL and testbench

Parametrised multi-lane parallel-to-serial converter. It is the next generation of the fixed 4-lane, 8-bit p2s block.
- Accepts one LANES*WIDTH-bit word through a valid/ready handshake.
- Buffers one word in a holding register.
- Shifts each lane's WIDTH bits out serially, one bit per enabled cycle, with selectable bit order.
- Rate selection uses a shift-enable strobe from the frequency-divider logic instead of muxed clocks. Back-to-back words stream without gaps.

---
 rtl/p2s_lanes_param_pkg.sv | 15 +
 rtl/p2s_lanes_param_lane_shift.sv | 35 +++
 rtl/p2s_lanes_param.sv | 114 +++++++++++
 tb/tb_p2s_lanes_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_lanes_param_pkg.sv
// rtl/p2s_lanes_param_pkg.sv - shared FSM state type and counter sizing for the multi-lane p2s
package p2s_lanes_param_pkg;

  // Two-state shifter control: idle (lanes parked) or shifting a word
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit counter width for a WIDTH-bit lane; never narrower than one bit
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/p2s_lanes_param_lane_shift.sv
// rtl/p2s_lanes_param_lane_shift.sv - one loadable WIDTH-bit lane shift register
module p2s_lane_shift #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  // Load wins over shift; shifting moves the next bit toward the output end
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Lane register, cleared asynchronously so a partial word is discarded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end

  assign bit_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/p2s_lanes_param.sv
// rtl/p2s_lanes_param.sv - parametrised multi-lane parallel-to-serial converter with holding register
module p2s_lanes_param
  import p2s_lanes_param_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_VAL  = 1'b0
) (
  input  logic                   IN_CLK_p2s,
  input  logic                   IN_RESET_p2s,
  input  logic                   IN_ENB_p2s,
  input  logic [LANES*WIDTH-1:0] IN_DATA_p2s,
  input  logic                   IN_VALID_p2s,
  output logic                   OUT_READY_p2s,
  output logic [LANES-1:0]       OUT_LANE_p2s,
  output logic                   OUT_VALID_p2s,
  output logic                   OUT_FIRST_p2s
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   load, shift, accept;
  logic [LANES-1:0]       lane_bit;

  // Ready comes straight from the hold flag, so accept never overlaps a transfer
  assign accept = IN_VALID_p2s & ~hold_full_q;

  // Next state, counter and lane controls; a strobe at the last bit reloads without a gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (IN_ENB_p2s && hold_full_q) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (IN_ENB_p2s) begin
          if (cnt_q != CNT_LAST) begin
            shift = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else if (hold_full_q) begin
            load  = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register fills on handshake and empties when its word moves into the lanes
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = IN_DATA_p2s;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  // Control and holding state registers
  always_ff @(posedge IN_CLK_p2s or posedge IN_RESET_p2s) begin
    if (IN_RESET_p2s) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      p2s_lane_shift #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
      ) u_lane (
        .clk_i  (IN_CLK_p2s),
        .rst_i  (IN_RESET_p2s),
        .load_i (load),
        .shift_i(shift),
        .data_i (hold_q[gi*WIDTH +: WIDTH]),
        .bit_o  (lane_bit[gi])
      );
    end
  endgenerate

  assign OUT_READY_p2s = ~hold_full_q;
  assign OUT_VALID_p2s = (state_q == ST_SHIFT);
  assign OUT_FIRST_p2s = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign OUT_LANE_p2s  = (state_q == ST_SHIFT) ? lane_bit : {LANES{IDLE_VAL}};

endmodule

// File: tb/tb_p2s_lanes_param.sv
// tb/tb_p2s_lanes_param.sv - scoreboard bench for p2s_lanes_param (default and LSB-first configs)
module tb_p2s_lanes_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [31:0] in_data;
  logic        in_valid;
  logic        o_ready, o_valid, o_first;
  logic [3:0]  o_lane;

  logic [9:0]  in_data2;
  logic        in_valid2;
  logic        o_ready2, o_valid2, o_first2;
  logic [1:0]  o_lane2;

  int checks = 0;
  int errors = 0;
  int enb_div = 1;
  int cyc = 0;

  logic [4:0] q1[$];
  logic [2:0] q2[$];

  int ncyc1 = 0, vcount1 = 0, first_v1 = 0, last_v1 = 0, firsts1 = 0, pops1 = 0;
  int vcount2 = 0;
  logic [7:0] cap0, cap3;
  logic [4:0] cap20;

  always #5 clk = ~clk;

  p2s_lanes_param dut (
    .IN_CLK_p2s   (clk),
    .IN_RESET_p2s (rst),
    .IN_ENB_p2s   (enb),
    .IN_DATA_p2s  (in_data),
    .IN_VALID_p2s (in_valid),
    .OUT_READY_p2s(o_ready),
    .OUT_LANE_p2s (o_lane),
    .OUT_VALID_p2s(o_valid),
    .OUT_FIRST_p2s(o_first)
  );

  p2s_lanes_param #(.LANES(2), .WIDTH(5), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0)) dut2 (
    .IN_CLK_p2s   (clk),
    .IN_RESET_p2s (rst),
    .IN_ENB_p2s   (enb),
    .IN_DATA_p2s  (in_data2),
    .IN_VALID_p2s (in_valid2),
    .OUT_READY_p2s(o_ready2),
    .OUT_LANE_p2s (o_lane2),
    .OUT_VALID_p2s(o_valid2),
    .OUT_FIRST_p2s(o_first2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift strobe: every enb_div-th cycle, driven just after the edge
  initial begin
    enb = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      enb = (enb_div <= 1) || ((cyc % enb_div) == 0);
    end
  end

  // Monitor for the default 4x8 MSB-first instance
  initial begin
    forever begin
      @(negedge clk);
      ncyc1++;
      if (!rst && o_valid) begin
        if (vcount1 == 0) first_v1 = ncyc1;
        last_v1 = ncyc1;
        vcount1++;
        if (o_first) firsts1++;
        chk("expect_pending1", (q1.size() != 0), 1);
        if (q1.size() != 0) begin
          chk("lane_bits1", {27'd0, o_first, o_lane}, {27'd0, q1[0]});
          if (enb) begin
            void'(q1.pop_front());
            pops1++;
            cap0 = {cap0[6:0], o_lane[0]};
            cap3 = {cap3[6:0], o_lane[3]};
          end
        end
      end
    end
  end

  // Monitor for the 2x5 LSB-first instance
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && o_valid2) begin
        vcount2++;
        chk("expect_pending2", (q2.size() != 0), 1);
        if (q2.size() != 0) begin
          chk("lane_bits2", {29'd0, o_first2, o_lane2}, {29'd0, q2[0]});
          if (enb) begin
            void'(q2.pop_front());
            cap20 = {cap20[3:0], o_lane2[0]};
          end
        end
      end
    end
  end

  // Offer a word on the 4x8 instance; on accept queue its expected bit stream
  task automatic push1(input logic [31:0] d);
    logic r;
    logic [4:0] e;
    bit done;
    done = 0;
    in_data = d;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      r = o_ready;
      @(posedge clk);
      if (r) begin
        done = 1;
        for (int b = 0; b < 8; b++) begin
          for (int l = 0; l < 4; l++) e[l] = d[l*8 + 7 - b];
          e[4] = (b == 0);
          q1.push_back(e);
        end
      end
    end
    #1;
    chk("push1_accepted", {31'd0, done}, 1);
    chk("ready_low_hold_full", {31'd0, o_ready}, 0);
  endtask

  task automatic push2(input logic [9:0] d);
    logic r;
    logic [2:0] e;
    bit done;
    done = 0;
    in_data2 = d;
    in_valid2 = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      r = o_ready2;
      @(posedge clk);
      if (r) begin
        done = 1;
        for (int b = 0; b < 5; b++) begin
          for (int l = 0; l < 2; l++) e[l] = d[l*5 + b];
          e[2] = (b == 0);
          q2.push_back(e);
        end
      end
    end
    #1;
    in_valid2 = 1'b0;
    chk("push2_accepted", {31'd0, done}, 1);
  endtask

  task automatic wait_idle1();
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(posedge clk);
      #2;
      if (q1.size() == 0 && !o_valid) ok = 1;
    end
    chk("drain1", {31'd0, ok}, 1);
  endtask

  task automatic wait_idle2();
    bit ok;
    ok = 0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(posedge clk);
      #2;
      if (q2.size() == 0 && !o_valid2) ok = 1;
    end
    chk("drain2", {31'd0, ok}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hit;
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    in_data2 = '0;
    in_valid2 = 1'b0;
    cap0 = '0;
    cap3 = '0;
    cap20 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle with strobe running and no handshake
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, o_ready}, 1);
      chk("idle_valid", {31'd0, o_valid}, 0);
      chk("idle_first", {31'd0, o_first}, 0);
      chk("idle_lane", {28'd0, o_lane}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Single word, continuous strobe
    vcount1 = 0; firsts1 = 0;
    push1({8'h3C, 8'hF0, 8'h0F, 8'hA5});
    in_valid = 1'b0;
    wait_idle1();
    chk("single_valid_cycles", vcount1, 8);
    chk("single_first_pulses", firsts1, 1);
    chk("single_lane0_stream", {24'd0, cap0}, 32'hA5);
    chk("single_lane3_stream", {24'd0, cap3}, 32'h3C);

    // Three words back to back with valid held
    vcount1 = 0; firsts1 = 0;
    push1(32'h1234_5678);
    push1(32'hDEAD_BEEF);
    push1(32'h0F0F_C3C3);
    in_valid = 1'b0;
    wait_idle1();
    chk("b2b_valid_cycles", vcount1, 24);
    chk("b2b_contiguous_span", last_v1 - first_v1 + 1, 24);
    chk("b2b_first_pulses", firsts1, 3);

    // Strobe every 4th cycle: each bit stretched over 4 cycles
    enb_div = 4;
    vcount1 = 0; firsts1 = 0;
    push1({8'h3C, 8'hF0, 8'h0F, 8'hA5});
    in_valid = 1'b0;
    wait_idle1();
    chk("div4_valid_cycles", vcount1, 32);
    chk("div4_lane0_stream", {24'd0, cap0}, 32'hA5);
    chk("div4_lane3_stream", {24'd0, cap3}, 32'h3C);
    enb_div = 1;
    repeat (4) @(posedge clk);
    #1;

    // LSB-first 2x5 instance: lane0 = 10110 emits 0,1,1,0,1
    vcount2 = 0;
    push2({5'b01001, 5'b10110});
    wait_idle2();
    chk("lsb_valid_cycles", vcount2, 5);
    chk("lsb_lane0_stream", {27'd0, cap20}, 32'b01101);

    // Asynchronous reset mid-word at bit 3 with the hold register full
    pops1 = 0;
    push1(32'hA5A5_A5A5);
    push1(32'h5A5A_5A5A);
    in_valid = 1'b0;
    hit = 0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(posedge clk);
      #2;
      if (pops1 == 3) hit = 1;
    end
    chk("reach_bit3", {31'd0, hit}, 1);
    chk("mid_word_valid", {31'd0, o_valid}, 1);
    chk("mid_word_hold_full", {31'd0, o_ready}, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 0);
    chk("async_rst_ready", {31'd0, o_ready}, 1);
    chk("async_rst_first", {31'd0, o_first}, 0);
    chk("async_rst_lane", {28'd0, o_lane}, 32'h0);
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, o_valid}, 0);
      chk("post_rst_ready", {31'd0, o_ready}, 1);
    end

    chk("q1_empty_end", q1.size(), 0);
    chk("q2_empty_end", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
